freq_sweep_ctrl: RTL and testbench
==================================

FREQ_SWEEP_CTRL -- requirements
Module: freq_sweep_ctrl

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 200000000, meaning system clock in Hz, for documentation only.
REQ-002 The block SHALL have parameter MAX_FREQ, default 2500000, meaning upper legal frequency in Hz.
REQ-003 The block SHALL have parameter MIN_FREQ, default 1, meaning lower legal frequency in Hz.
REQ-004 The block SHALL have these ports:
- clk  input  1  sole clock; all logic on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- start  input  1  single-cycle sweep request.
- abort  input  1  stop the sweep immediately.
- cont  input  1  0 = single sweep; 1 = repeat continuously.
- start_freq  input  23  first frequency (Hz).
- stop_freq  input  23  last frequency (Hz).
- step  input  23  increment magnitude (Hz).
- dwell  input  32  clock cycles spent at each frequency.
- freq_C2  output  23  commanded frequency to the DDFS frequency converter.
- freq_valid  output  1  1-cycle pulse whenever freq_C2 changes.
- busy  output  1  high outside IDLE.
- done  output  1  1-cycle pulse at single-sweep completion.
- err  output  1  1-cycle pulse on a rejected start.

Function
REQ-005 The FSM SHALL have the states IDLE, DWELL, STEP and FINISH.
REQ-006 In IDLE with start=1, the configuration SHALL be valid when all of these hold: MIN_FREQ<=start_freq<=MAX_FREQ, MIN_FREQ<=stop_freq<=MAX_FREQ, and step!=0.
REQ-007 On a valid start, the block SHALL latch start_freq, stop_freq, step, dwell and cont, and SHALL set direction up if stop_freq>=start_freq, else down.
REQ-008 On the same valid start edge, freq_C2 SHALL load start_freq, freq_valid SHALL pulse, and the FSM SHALL enter DWELL; latency from start to freq_C2 is 1 cycle.
REQ-009 On an invalid start, err SHALL pulse for 1 cycle, the FSM SHALL stay in IDLE, and freq_C2 SHALL remain unchanged.
REQ-010 In DWELL, the dwell counter SHALL run for max(dwell,1) cycles, then the FSM SHALL enter STEP.
REQ-011 In STEP with freq_C2==latched stop, the block SHALL go to FINISH if cont=0; if cont=1 it SHALL reload the latched start, pulse freq_valid and go to DWELL.
REQ-012 In STEP otherwise, the next frequency SHALL be freq_C2±step computed on 24 bits, saturated to the latched stop if it passes stop; freq_valid SHALL pulse and the FSM SHALL go to DWELL.
REQ-013 The block SHALL never drive freq_C2 outside [MIN_FREQ, MAX_FREQ].
REQ-014 FINISH SHALL pulse done for 1 cycle, return to IDLE next cycle, and hold freq_C2.
REQ-015 abort=1 in any non-IDLE state SHALL move the FSM to IDLE on the next edge, with freq_C2 held, no done pulse and no freq_valid pulse.
REQ-016 abort SHALL have priority over the STEP/DWELL transitions.
REQ-017 abort in IDLE SHALL be ignored.
REQ-018 start SHALL be ignored while busy=1, and input changes SHALL NOT affect the running sweep.
REQ-019 If start and abort are high together in IDLE, start SHALL be processed.
REQ-020 A start_freq==stop_freq sweep SHALL dwell once and then finish (cont=0), or repeat that frequency (cont=1).

Reset
REQ-021 While rst_n=0 at a clock edge, the FSM SHALL be IDLE, freq_C2=MIN_FREQ, the dwell counter and latched registers SHALL be 0, and freq_valid, busy, done and err SHALL be 0.
REQ-022 A reset asserted mid-sweep SHALL take effect on the next edge with no done pulse.
REQ-023 The block SHALL have no asynchronous reset path.

Structure
REQ-024 Package ddfs_pkg SHALL hold FREQ_W=23, the default MIN_FREQ/MAX_FREQ, and the sweep state enumeration, shared with the frequency select and converter blocks.
REQ-025 The dwell counter SHALL be a sub-module sweep_dwell_timer (load, count, expire pulse).
REQ-026 The FSM and arithmetic SHALL stay in freq_sweep_ctrl.

Verification
REQ-027 Single up-sweep: start=1, dwell=4, cont=0, start_freq=10, stop_freq=20, step=5 -> freq_C2 = 10, 15, 20, each held 4 cycles; done pulses once; busy falls.
REQ-028 Down-sweep with saturation: start_freq=100, stop_freq=90, step=3 -> 100, 97, 94, 91, 90, then done.
REQ-029 Continuous: start_freq=1, stop_freq=3, step=1, cont=1 -> 1, 2, 3, 1, 2, ... repeating; abort mid-DWELL -> IDLE next cycle, freq_C2 held, no done.
REQ-030 Invalid configs: step=0, or stop_freq=2500001 -> err pulse, busy stays 0, freq_C2 unchanged.
REQ-031 start asserted while busy -> ignored; start and abort together in IDLE -> sweep begins.
REQ-032 rst_n=0 during DWELL at freq_C2=15 -> next cycle freq_C2=1, busy=0, done=0; dwell=0 -> each frequency held exactly 1 cycle.

Source files
------------

// File: rtl/ddfs_pkg.sv
// Shared definitions for the DDFS sweep, frequency select and converter blocks.
package ddfs_pkg;

   localparam int FREQ_W       = 23;
   localparam int DEF_MIN_FREQ = 1;
   localparam int DEF_MAX_FREQ = 2500000;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DWELL  = 2'd1,
      ST_STEP   = 2'd2,
      ST_FINISH = 2'd3
   } sweep_state_e;

endpackage

// File: rtl/sweep_dwell_timer.sv
// Down-counter that measures the dwell time at one sweep frequency.
module sweep_dwell_timer (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic [31:0] load_val,
   input  logic        count,
   output logic        expire
);

   logic [31:0] cnt_d;
   logic [31:0] cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (count && (cnt_q != 32'd0)) begin
         cnt_d = cnt_q - 32'd1;
      end
   end

   // Expire marks the last counting cycle so the caller can leave on the next edge.
   assign expire = count && !load && (cnt_q == 32'd1);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/freq_sweep_ctrl.sv
// Frequency sweep controller: steps the DDFS command frequency from start to stop,
// holding each value for max(dwell,1) cycles, single-shot or continuous.
module freq_sweep_ctrl
   import ddfs_pkg::*;
#(
   parameter int CLK_FREQ = 200000000,
   parameter int MAX_FREQ = DEF_MAX_FREQ,
   parameter int MIN_FREQ = DEF_MIN_FREQ
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic              cont,
   input  logic [FREQ_W-1:0] start_freq,
   input  logic [FREQ_W-1:0] stop_freq,
   input  logic [FREQ_W-1:0] step,
   input  logic [31:0]       dwell,
   output logic [FREQ_W-1:0] freq_C2,
   output logic              freq_valid,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam logic [FREQ_W-1:0] MIN_F = FREQ_W'(MIN_FREQ);
   localparam logic [FREQ_W-1:0] MAX_F = FREQ_W'(MAX_FREQ);

   if ((CLK_FREQ < 1) || (MIN_FREQ < 1) || (MAX_FREQ < MIN_FREQ)) begin : g_bad_cfg
      $error("freq_sweep_ctrl: inconsistent frequency parameters");
   end

   // Next sweep point on 24 bits, clamped to the stop frequency once it is passed.
   function automatic logic [FREQ_W-1:0] next_freq(
      input logic [FREQ_W-1:0] cur,
      input logic [FREQ_W-1:0] stp,
      input logic [FREQ_W-1:0] stop,
      input logic              up
   );
      logic [FREQ_W:0] sum;
      if (up) begin
         sum = {1'b0, cur} + {1'b0, stp};
         if (sum > {1'b0, stop}) return stop;
      end else begin
         sum = {1'b0, cur} - {1'b0, stp};
         if (sum[FREQ_W] || (sum < {1'b0, stop})) return stop;
      end
      return sum[FREQ_W-1:0];
   endfunction

   sweep_state_e      state_d, state_q;
   logic [FREQ_W-1:0] freq_d, freq_q;
   logic [FREQ_W-1:0] start_l_d, start_l_q;
   logic [FREQ_W-1:0] stop_l_d, stop_l_q;
   logic [FREQ_W-1:0] step_l_d, step_l_q;
   logic [31:0]       dwell_l_d, dwell_l_q;
   logic              cont_d, cont_q;
   logic              up_d, up_q;
   logic              valid_d, valid_q;
   logic              busy_d, busy_q;
   logic              done_d, done_q;
   logic              err_d, err_q;

   logic              cfg_ok;
   logic [31:0]       dwell_sel;
   sweep_state_e      hold_st;
   logic              tmr_load;
   logic              tmr_expire;

   assign cfg_ok = (start_freq >= MIN_F) && (start_freq <= MAX_F) &&
                   (stop_freq >= MIN_F) && (stop_freq <= MAX_F) && (step != '0);

   // The timer covers the hold minus the STEP cycle; a one-cycle hold skips DWELL.
   assign dwell_sel = (state_q == ST_IDLE) ? dwell : dwell_l_q;
   assign hold_st   = (dwell_sel <= 32'd1) ? ST_STEP : ST_DWELL;

   sweep_dwell_timer u_dwell_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (tmr_load),
      .load_val (dwell_sel - 32'd1),
      .count    (state_q == ST_DWELL),
      .expire   (tmr_expire)
   );

   always_comb begin
      state_d   = state_q;
      freq_d    = freq_q;
      start_l_d = start_l_q;
      stop_l_d  = stop_l_q;
      step_l_d  = step_l_q;
      dwell_l_d = dwell_l_q;
      cont_d    = cont_q;
      up_d      = up_q;
      valid_d   = 1'b0;
      done_d    = 1'b0;
      err_d     = 1'b0;
      tmr_load  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (cfg_ok) begin
                  start_l_d = start_freq;
                  stop_l_d  = stop_freq;
                  step_l_d  = step;
                  dwell_l_d = dwell;
                  cont_d    = cont;
                  up_d      = (stop_freq >= start_freq);
                  freq_d    = start_freq;
                  valid_d   = 1'b1;
                  tmr_load  = 1'b1;
                  state_d   = hold_st;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         ST_DWELL: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (tmr_expire) begin
               state_d = ST_STEP;
            end
         end
         ST_STEP: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if ((freq_q == stop_l_q) && !cont_q) begin
               state_d = ST_FINISH;
               done_d  = 1'b1;
            end else begin
               freq_d   = (freq_q == stop_l_q) ? start_l_q
                        : next_freq(freq_q, step_l_q, stop_l_q, up_q);
               valid_d  = 1'b1;
               tmr_load = 1'b1;
               state_d  = hold_st;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         freq_q    <= MIN_F;
         start_l_q <= '0;
         stop_l_q  <= '0;
         step_l_q  <= '0;
         dwell_l_q <= '0;
         cont_q    <= 1'b0;
         up_q      <= 1'b0;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         freq_q    <= freq_d;
         start_l_q <= start_l_d;
         stop_l_q  <= stop_l_d;
         step_l_q  <= step_l_d;
         dwell_l_q <= dwell_l_d;
         cont_q    <= cont_d;
         up_q      <= up_d;
         valid_q   <= valid_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   assign freq_C2    = freq_q;
   assign freq_valid = valid_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign err        = err_q;

endmodule

// File: tb/tb_freq_sweep_ctrl.sv
// Bench for freq_sweep_ctrl: frequency sequences come from a list-based sweep model.
module tb_freq_sweep_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        abort;
   logic        cont;
   logic [22:0] start_freq;
   logic [22:0] stop_freq;
   logic [22:0] step;
   logic [31:0] dwell;
   logic [22:0] freq_C2;
   logic        freq_valid;
   logic        busy;
   logic        done;
   logic        err;

   int checks = 0;
   int errors = 0;
   int last_freq = 1;
   int exp_q[$];

   freq_sweep_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .abort      (abort),
      .cont       (cont),
      .start_freq (start_freq),
      .stop_freq  (stop_freq),
      .step       (step),
      .dwell      (dwell),
      .freq_C2    (freq_C2),
      .freq_valid (freq_valid),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Every frequency visited by one pass of the sweep, in order.
   task automatic build_seq(input int s, input int e, input int st);
      int f;
      exp_q.delete();
      f = s;
      while (1) begin
         exp_q.push_back(f);
         if (f == e) break;
         if (e > f) f = (f + st > e) ? e : f + st;
         else       f = (f - st < e) ? e : f - st;
      end
   endtask

   task automatic check_hold(input string name, input int f, input bit first);
      checks++;
      if (freq_C2 !== 23'(f)) begin
         errors++; $display("FAIL %s freq_C2: got %0d expected %0d", name, freq_C2, f);
      end
      checks++;
      if (freq_valid !== first || busy !== 1'b1 || done !== 1'b0) begin
         errors++;
         $display("FAIL %s flags: valid=%b busy=%b done=%b expected valid=%b busy=1 done=0",
                  name, freq_valid, busy, done, first);
      end
   endtask

   // One single-shot sweep; with disturb set, start and the config inputs toggle throughout.
   task automatic run_sweep(input string name, input int s, input int e, input int st,
                            input int dw, input bit disturb);
      int n;
      build_seq(s, e, st);
      n = (dw == 0) ? 1 : dw;
      start_freq = 23'(s); stop_freq = 23'(e); step = 23'(st); dwell = 32'(dw);
      cont = 1'b0; abort = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      foreach (exp_q[i]) begin
         for (int c = 0; c < n; c++) begin
            if (c > 0 || i > 0) tick();
            check_hold(name, exp_q[i], c == 0);
            if (disturb) begin
               start = 1'($urandom_range(1, 0));
               cont = 1'($urandom_range(1, 0));
               start_freq = 23'($urandom_range(50, 1));
               stop_freq = 23'($urandom_range(50, 1));
               step = 23'($urandom_range(9, 1));
               dwell = 32'($urandom_range(3, 0));
            end
         end
      end
      tick();
      start = 1'b0;
      checks++;
      if (done !== 1'b1 || busy !== 1'b1 || freq_valid !== 1'b0 || freq_C2 !== 23'(e)) begin
         errors++;
         $display("FAIL %s finish: done=%b busy=%b valid=%b freq=%0d expected 1 1 0 %0d",
                  name, done, busy, freq_valid, freq_C2, e);
      end
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || freq_C2 !== 23'(e)) begin
         errors++;
         $display("FAIL %s idle: done=%b busy=%b freq=%0d expected 0 0 %0d",
                  name, done, busy, freq_C2, e);
      end
      last_freq = e;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; cont = 1'b0;
      start_freq = '0; stop_freq = '0; step = '0; dwell = '0;
      repeat (3) tick();
      rst_n = 1'b1;
      checks++;
      if (freq_C2 !== 23'd1 || freq_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
         errors++;
         $display("FAIL reset: freq=%0d valid=%b busy=%b done=%b err=%b expected 1 0 0 0 0",
                  freq_C2, freq_valid, busy, done, err);
      end
      tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      checks++;
      if (busy !== 1'b0 || freq_C2 !== 23'd1) begin
         errors++; $display("FAIL idle_abort: busy=%b freq=%0d expected 0 1", busy, freq_C2);
      end
   endtask

   task automatic test_directed_sweeps();
      run_sweep("up_sweep", 10, 20, 5, 4, 1'b0);
      run_sweep("down_sat", 100, 90, 3, 2, 1'b0);
      run_sweep("dwell0", 3, 9, 2, 0, 1'b0);
      run_sweep("dwell1", 9, 3, 4, 1, 1'b0);
      run_sweep("same_freq", 42, 42, 7, 3, 1'b0);
      run_sweep("top_edge", 2499990, 2500000, 7, 1, 1'b0);
      run_sweep("bottom_edge", 20, 1, 6, 2, 1'b0);
   endtask

   task automatic test_random_sweeps();
      for (int k = 0; k < 12; k++) begin
         run_sweep("random", int'($urandom_range(60, 1)), int'($urandom_range(60, 1)),
                   int'($urandom_range(20, 1)), int'($urandom_range(4, 0)), 1'b0);
      end
   endtask

   task automatic test_busy_start();
      run_sweep("busy_start", 5, 30, 4, 3, 1'b1);
      run_sweep("busy_start_dn", 40, 11, 6, 0, 1'b1);
   endtask

   task automatic test_continuous_abort();
      build_seq(1, 3, 1);
      start_freq = 23'd1; stop_freq = 23'd3; step = 23'd1; dwell = 32'd2;
      cont = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      for (int p = 0; p < 3; p++) begin
         foreach (exp_q[i]) begin
            for (int c = 0; c < 2; c++) begin
               if (p > 0 || i > 0 || c > 0) tick();
               check_hold("continuous", exp_q[i], c == 0);
            end
         end
      end
      tick();
      check_hold("continuous", 1, 1'b1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      checks++;
      if (busy !== 1'b0 || freq_C2 !== 23'd1 || done !== 1'b0 || freq_valid !== 1'b0) begin
         errors++;
         $display("FAIL abort: busy=%b freq=%0d done=%b valid=%b expected 0 1 0 0",
                  busy, freq_C2, done, freq_valid);
      end
      repeat (3) tick();
      checks++;
      if (busy !== 1'b0 || freq_C2 !== 23'd1 || done !== 1'b0) begin
         errors++; $display("FAIL abort_hold: busy=%b freq=%0d done=%b expected 0 1 0", busy, freq_C2, done);
      end
      cont = 1'b0;
      last_freq = 1;
   endtask

   task automatic test_invalid();
      int bad_s[3] = '{5, 5, 0};
      int bad_e[3] = '{10, 2500001, 10};
      int bad_st[3] = '{0, 1, 1};
      for (int k = 0; k < 3; k++) begin
         start_freq = 23'(bad_s[k]); stop_freq = 23'(bad_e[k]); step = 23'(bad_st[k]);
         dwell = 32'd2; start = 1'b1;
         tick();
         start = 1'b0;
         checks++;
         if (err !== 1'b1 || busy !== 1'b0 || freq_valid !== 1'b0 || freq_C2 !== 23'(last_freq)) begin
            errors++;
            $display("FAIL invalid_%0d: err=%b busy=%b valid=%b freq=%0d expected 1 0 0 %0d",
                     k, err, busy, freq_valid, freq_C2, last_freq);
         end
         tick();
         checks++;
         if (err !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL invalid_pulse_%0d: err=%b busy=%b expected 0 0", k, err, busy);
         end
      end
   endtask

   task automatic test_start_abort();
      start_freq = 23'd7; stop_freq = 23'd7; step = 23'd1; dwell = 32'd0;
      cont = 1'b0; start = 1'b1; abort = 1'b1;
      tick();
      start = 1'b0; abort = 1'b0;
      check_hold("start_abort", 7, 1'b1);
      tick();
      checks++;
      if (done !== 1'b1 || freq_C2 !== 23'd7) begin
         errors++; $display("FAIL start_abort_done: done=%b freq=%0d expected 1 7", done, freq_C2);
      end
      tick();
      last_freq = 7;
   endtask

   task automatic test_reset_mid_sweep();
      start_freq = 23'd10; stop_freq = 23'd20; step = 23'd5; dwell = 32'd4;
      cont = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) tick();
      check_hold("rst_mid_pre", 15, 1'b1);
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      checks++;
      if (freq_C2 !== 23'd1 || busy !== 1'b0 || done !== 1'b0 || freq_valid !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid: freq=%0d busy=%b done=%b valid=%b expected 1 0 0 0",
                  freq_C2, busy, done, freq_valid);
      end
      repeat (6) tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || freq_C2 !== 23'd1) begin
         errors++; $display("FAIL rst_mid_after: done=%b busy=%b freq=%0d expected 0 0 1", done, busy, freq_C2);
      end
      last_freq = 1;
   endtask

   initial begin
      test_reset();
      test_directed_sweeps();
      test_invalid();
      test_random_sweeps();
      test_busy_start();
      test_continuous_abort();
      test_start_abort();
      test_reset_mid_sweep();
      test_invalid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
